// File: rtl/iddmm_final_sel_if.sv
// iddmm_final_sel_if: word-serial input stream and selected-result output stream
interface iddmm_final_sel_if #(
    parameter int K      = 256,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_idx;
    logic [K-1:0]      in_raw;
    logic [K-1:0]      in_diff;
    logic              in_borrow;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [K-1:0]      out_data;
    logic              out_last;
    logic              out_sel;
    logic              err;

    modport master (
        output in_valid, in_idx, in_raw, in_diff, in_borrow, out_ready,
        input  in_ready, out_valid, out_idx, out_data, out_last, out_sel, err
    );

    modport slave (
        input  in_valid, in_idx, in_raw, in_diff, in_borrow, out_ready,
        output in_ready, out_valid, out_idx, out_data, out_last, out_sel, err
    );
endinterface

// File: rtl/iddmm_final_sel.sv
// iddmm_final_sel: buffers a raw/diff frame and replays raw when the final borrow is set, else diff
module iddmm_final_sel #(
    parameter int K      = 256,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input logic              clk,
    input logic              rst_n,
    iddmm_final_sel_if.slave bus
);
    typedef enum logic {COLLECT, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] exp_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              sel_q;
    logic              err_q;
    logic [K-1:0]      raw_buf  [N];
    logic [K-1:0]      diff_buf [N];
    logic              accept;
    logic              in_order;
    logic              handshake;

    assign accept    = bus.in_valid & (state_q == COLLECT);
    assign in_order  = accept & (bus.in_idx == exp_q);
    assign handshake = (state_q == DRAIN) & bus.out_ready;

    // Frame sequencer: expected-index tracking, borrow latch and drain pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            exp_q    <= '0;
            rd_ptr_q <= '0;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept & ~in_order;
            if (accept) begin
                exp_q <= (!in_order || exp_q == LAST) ? '0 : exp_q + 1'b1;
                if (in_order && exp_q == LAST) begin
                    sel_q   <= bus.in_borrow;
                    state_q <= DRAIN;
                end
            end
            if (handshake) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
                if (rd_ptr_q == LAST)
                    state_q <= COLLECT;
            end
        end
    end

    // Operand buffers: written only by in-order accepts, contents survive reset
    always_ff @(posedge clk) begin
        if (in_order) begin
            raw_buf[bus.in_idx]  <= bus.in_raw;
            diff_buf[bus.in_idx] <= bus.in_diff;
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_idx   = rd_ptr_q;
    assign bus.out_data  = (state_q == DRAIN) ? (sel_q ? raw_buf[rd_ptr_q] : diff_buf[rd_ptr_q]) : '0;
    assign bus.out_last  = (state_q == DRAIN) & (rd_ptr_q == LAST);
    assign bus.out_sel   = sel_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_iddmm_final_sel.sv
// tb_iddmm_final_sel: directed frames with a scoreboard of expected output words
module tb_iddmm_final_sel;
    localparam int K = 8;
    localparam int N = 4;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
        logic       sel;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   busy   = 0;
    exp_t sb[$];

    logic [3:0][7:0] raw_a  = {8'h40, 8'h30, 8'h20, 8'h10};
    logic [3:0][7:0] diff_a = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
    logic [3:0][7:0] raw_b  = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
    logic [3:0][7:0] diff_b = {8'hE4, 8'hE3, 8'hE2, 8'hE1};

    iddmm_final_sel_if #(.K(K), .N(N)) bus ();

    iddmm_final_sel #(.K(K), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [1:0] idx, input logic [7:0] r, input logic [7:0] d, input logic b);
        bus.in_valid  = 1'b1;
        bus.in_idx    = idx;
        bus.in_raw    = r;
        bus.in_diff   = d;
        bus.in_borrow = b;
        check("in_ready_collect", 32'(bus.in_ready), 32'd1);
        step();
    endtask

    task automatic send_frame(input logic [3:0][7:0] r, input logic [3:0][7:0] d, input logic [3:0] b, input bit keep);
        for (int i = 0; i < N; i++)
            send_word(2'(i), r[i], d[i], b[i]);
        for (int i = 0; i < N; i++)
            sb.push_back('{idx: 2'(i), data: b[3] ? r[i] : d[i], last: (i == N - 1), sel: b[3]});
        if (!keep)
            bus.in_valid = 1'b0;
        check("out_valid_rise", 32'(bus.out_valid), 32'd1);
        check("out_sel_latched", 32'(bus.out_sel), 32'(b[3]));
    endtask

    task automatic drain(input bit stall, input int words);
        int   p    = 0;
        int   hs   = 0;
        int   cyc  = 0;
        bit   held = 0;
        exp_t e;
        exp_t h;
        busy = 0;
        while (sb.size() > 0 && hs < words && cyc < 60) begin
            bus.out_ready = stall ? (p % 3 == 0) : 1'b1;
            p++;
            if (bus.in_ready === 1'b0)
                busy++;
            check("err_quiet_drain", 32'(bus.err), 32'd0);
            if (held) begin
                check("hold_idx", 32'(bus.out_idx), 32'(h.idx));
                check("hold_data", 32'(bus.out_data), 32'(h.data));
                check("hold_last", 32'(bus.out_last), 32'(h.last));
                check("hold_sel", 32'(bus.out_sel), 32'(h.sel));
            end
            held = 0;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                e = sb.pop_front();
                check("out_idx", 32'(bus.out_idx), 32'(e.idx));
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_last", 32'(bus.out_last), 32'(e.last));
                check("out_sel", 32'(bus.out_sel), 32'(e.sel));
                hs++;
            end else if (bus.out_valid === 1'b1) begin
                held   = 1;
                h.idx  = bus.out_idx;
                h.data = bus.out_data;
                h.last = bus.out_last;
                h.sel  = bus.out_sel;
            end
            step();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("handshake_count", 32'(hs), 32'(words));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_raw    = '0;
        bus.in_diff   = '0;
        bus.in_borrow = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check_idle("reset");
        check("reset_out_idx", 32'(bus.out_idx), 32'd0);
        check("reset_out_sel", 32'(bus.out_sel), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        step();

        // borrow set on the last word: raw words replayed
        send_frame(raw_a, diff_a, 4'b1000, 0);
        drain(0, 4);
        check_idle("after_borrow");

        // borrow clear on the last word: diff words replayed
        send_frame(raw_a, diff_a, 4'b0111, 0);
        drain(0, 4);
        check_idle("after_noborrow");

        // downstream stalls two of every three cycles
        send_frame(raw_b, diff_b, 4'b1000, 0);
        drain(1, 4);
        check_idle("after_backpressure");

        // out-of-order index drops the word and restarts the sequence
        send_word(2'd0, 8'h11, 8'h22, 1'b0);
        send_word(2'd1, 8'h11, 8'h22, 1'b0);
        send_word(2'd3, 8'h11, 8'h22, 1'b1);
        bus.in_valid = 1'b0;
        check("err_pulse", 32'(bus.err), 32'd1);
        check("err_no_drain", 32'(bus.out_valid), 32'd0);
        step();
        check("err_one_cycle", 32'(bus.err), 32'd0);
        send_frame(raw_b, diff_b, 4'b0000, 0);
        drain(0, 4);
        check_idle("after_seq_err");

        // reset asserted after two words of a frame have drained
        send_frame(raw_a, diff_a, 4'b1000, 0);
        drain(0, 2);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_out_idx", 32'(bus.out_idx), 32'd0);
        check("async_reset_out_sel", 32'(bus.out_sel), 32'd0);
        sb.delete();
        step();
        check_idle("held_reset");
        rst_n = 1'b1;
        step();
        send_frame(raw_b, diff_b, 4'b0111, 0);
        drain(0, 4);
        check_idle("after_reset_frame");

        // back-to-back frames with in_valid never dropped
        send_frame(raw_a, diff_a, 4'b1000, 1);
        bus.in_idx    = 2'd0;
        bus.in_raw    = raw_b[0];
        bus.in_diff   = diff_b[0];
        bus.in_borrow = 1'b0;
        drain(0, 4);
        check("b2b_busy_cycles", 32'(busy), 32'd4);
        send_frame(raw_b, diff_b, 4'b1000, 0);
        drain(0, 4);
        check_idle("after_b2b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
